// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter: pipeline writeback (A) has priority over FIFO-buffered
// multi-cycle results (B). A starvation counter briefly stalls A so B can drain.
module gpr_wb_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        a_valid,
    input  logic [4:0]  a_wa,
    input  logic [31:0] a_wd,
    input  logic [31:0] a_pc,
    output logic        a_stall,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_wa,
    input  logic [31:0] b_wd,
    input  logic [31:0] b_pc,
    output logic        RegWrite,
    output logic [4:0]  wa,
    output logic [31:0] wd,
    output logic [31:0] WPC,
    output logic [31:0] pend_mask,
    output logic        err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [4:0]       fwa_q [DEPTH];
    logic [31:0]      fwd_q [DEPTH];
    logic [31:0]      fpc_q [DEPTH];
    logic [DEPTH-1:0] fv_q;
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             a_stall_q, err_q, err_d;
    logic             regwrite_q;
    logic [4:0]       wa_q;
    logic [31:0]      wd_q, wpc_q;

    logic full, nonempty, push, pop, grant_a;

    always_comb begin
        full      = (count_q == CW'(DEPTH));
        nonempty  = (count_q != '0);
        push      = b_valid && !full && (b_wa != '0);
        grant_a   = a_valid && (a_wa != '0);
        // Any a_valid keeps the slot, even a discarded r0 write.
        pop       = !a_valid && nonempty;

        pend_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (fv_q[i]) begin
                pend_mask[fwa_q[i]] = 1'b1;
            end
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        starve_d = starve_q;
        if (grant_a) begin
            if (!nonempty) begin
                starve_d = '0;
            end else if (starve_q != SW'(STARVE_MAX)) begin
                starve_d = starve_q + SW'(1);
            end
        end else if (pop || !nonempty) begin
            starve_d = '0;
        end

        err_d = (a_valid && a_stall_q) || (grant_a && pend_mask[a_wa]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fv_q       <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            a_stall_q  <= 1'b0;
            err_q      <= 1'b0;
            regwrite_q <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
            wpc_q      <= '0;
        end else begin
            // Push and pop never address the same slot: that needs empty or full.
            if (push) begin
                fv_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q       <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                fv_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q       <= rd_ptr_q + AW'(1);
            end
            count_q   <= count_d;
            starve_q  <= starve_d;
            a_stall_q <= (starve_d == SW'(STARVE_MAX));
            err_q     <= err_d;

            if (grant_a) begin
                regwrite_q <= 1'b1;
                wa_q       <= a_wa;
                wd_q       <= a_wd;
                wpc_q      <= a_pc;
            end else if (pop) begin
                regwrite_q <= 1'b1;
                wa_q       <= fwa_q[rd_ptr_q];
                wd_q       <= fwd_q[rd_ptr_q];
                wpc_q      <= fpc_q[rd_ptr_q];
            end else begin
                regwrite_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fwa_q[wr_ptr_q] <= b_wa;
            fwd_q[wr_ptr_q] <= b_wd;
            fpc_q[wr_ptr_q] <= b_pc;
        end
    end

    assign b_ready  = !full;
    assign a_stall  = a_stall_q;
    assign err      = err_q;
    assign RegWrite = regwrite_q;
    assign wa       = wa_q;
    assign wd       = wd_q;
    assign WPC      = wpc_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Scoreboard bench for gpr_wb_arbiter: a queue-based reference model predicts each
// cycle's outputs; separate monitors compare them as the DUT presents results.
module tb_gpr_wb_arbiter;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_wa = '0, b_wa = '0;
    logic [31:0] a_wd = '0, a_pc = '0, b_wd = '0, b_pc = '0;
    logic        a_stall, b_ready, RegWrite, err;
    logic [4:0]  wa;
    logic [31:0] wd, WPC, pend_mask;

    gpr_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_wa(a_wa), .a_wd(a_wd), .a_pc(a_pc), .a_stall(a_stall),
        .b_valid(b_valid), .b_ready(b_ready), .b_wa(b_wa), .b_wd(b_wd), .b_pc(b_pc),
        .RegWrite(RegWrite), .wa(wa), .wd(wd), .WPC(WPC),
        .pend_mask(pend_mask), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] wa; logic [31:0] wd; logic [31:0] pc; } wr_t;
    typedef struct { logic rw; logic stall; logic err; } cyc_t;
    typedef struct { logic [31:0] pend; logic ready; } comb_t;

    wr_t   wr_q[$];
    cyc_t  cyc_q[$];
    comb_t comb_q[$];

    // Reference model state: pending B results in arrival order, starvation count.
    wr_t   mq[$];
    int    m_starve = 0;
    bit    m_stall  = 0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] pc_ctr = 32'h1000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic av, input logic [4:0] awa, input logic bv, input logic [4:0] bwa);
        comb_t c;
        cyc_t  e;
        wr_t   w;
        bit    nonempty;
        @(negedge clk);
        a_valid = av;  a_wa = awa;  a_wd = $urandom;  a_pc = pc_ctr;
        b_valid = bv;  b_wa = bwa;  b_wd = $urandom;  b_pc = pc_ctr + 32'h8000;
        pc_ctr  = pc_ctr + 4;

        c.ready = (mq.size() < DEPTH);
        c.pend  = '0;
        foreach (mq[i]) c.pend[mq[i].wa] = 1'b1;
        comb_q.push_back(c);

        nonempty = (mq.size() > 0);
        e.stall  = 1'b0;
        e.err    = (av && m_stall) || (av && awa != 0 && c.pend[awa]);
        e.rw     = 1'b0;
        if (av && awa != 0) begin
            e.rw = 1'b1;
            w.wa = awa; w.wd = a_wd; w.pc = a_pc;
            wr_q.push_back(w);
            m_starve = nonempty ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
        end else if (!av && nonempty) begin
            e.rw = 1'b1;
            wr_q.push_back(mq.pop_front());
            m_starve = 0;
        end else if (!nonempty) begin
            m_starve = 0;
        end
        if (bv && c.ready && bwa != 0) begin
            w.wa = bwa; w.wd = b_wd; w.pc = b_pc;
            mq.push_back(w);
        end
        m_stall = (m_starve >= STARVE_MAX);
        e.stall = m_stall;
        cyc_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_regwrite"}, {31'd0, RegWrite}, 32'd0);
        check({tag, "_wa"},       {27'd0, wa},       32'd0);
        check({tag, "_wd"},       wd,                32'd0);
        check({tag, "_wpc"},      WPC,               32'd0);
        check({tag, "_a_stall"},  {31'd0, a_stall},  32'd0);
        check({tag, "_err"},      {31'd0, err},      32'd0);
        check({tag, "_pend"},     pend_mask,         32'd0);
        check({tag, "_b_ready"},  {31'd0, b_ready},  32'd1);
    endtask

    // Registered-output monitor.
    initial begin
        cyc_t c;
        wr_t  w;
        forever begin
            @(posedge clk);
            #1;
            if (cyc_q.size() > 0) begin
                c = cyc_q.pop_front();
                check("regwrite", {31'd0, RegWrite}, {31'd0, c.rw});
                check("a_stall",  {31'd0, a_stall},  {31'd0, c.stall});
                check("err",      {31'd0, err},      {31'd0, c.err});
            end
            if (reset_n && RegWrite) begin
                n_checks++;
                if (wr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got wa=%0d wd=0x%08h expected no write at %0t", wa, wd, $time);
                end else begin
                    n_checks--;
                    w = wr_q.pop_front();
                    check("wa",  {27'd0, wa}, {27'd0, w.wa});
                    check("wd",  wd,  w.wd);
                    check("WPC", WPC, w.pc);
                end
            end
        end
    end

    // Combinational-output monitor.
    initial begin
        comb_t c;
        forever begin
            @(negedge clk);
            #2;
            if (comb_q.size() > 0) begin
                c = comb_q.pop_front();
                check("pend_mask", pend_mask, c.pend);
                check("b_ready",   {31'd0, b_ready}, {31'd0, c.ready});
            end
        end
    end

    initial begin
        #2;
        check_reset_outputs("reset0");
        @(negedge clk);
        reset_n = 1'b1;

        // single B result
        step(1'b0, 5'd0, 1'b1, 5'd5);
        idle(3);

        // A every cycle against one queued B entry; A backs off while stalled
        step(1'b0, 5'd0, 1'b1, 5'd9);
        for (int i = 0; i < 8; i++) step(!m_stall, 5'd12, 1'b0, 5'd0);
        idle(2);

        // fill the FIFO while A is busy, then overflow attempt and drain
        for (int i = 0; i < 6; i++) step(!m_stall, 5'd20, 1'b1, 5'(11 + i));
        idle(8);

        // r0 writes from either side
        step(1'b1, 5'd0, 1'b0, 5'd0);
        step(1'b0, 5'd0, 1'b1, 5'd0);
        step(1'b1, 5'd0, 1'b1, 5'd0);
        idle(2);

        // WAW: B r7 queued, then A r7
        step(1'b0, 5'd0, 1'b1, 5'd7);
        step(1'b1, 5'd7, 1'b0, 5'd0);
        idle(3);

        // random traffic, mostly obeying a_stall
        for (int i = 0; i < 400; i++) begin
            logic av;
            av = m_stall ? ($urandom_range(0, 99) < 5) : ($urandom_range(0, 99) < 60);
            step(av, 5'($urandom_range(0, 9)), ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 9)));
        end
        idle(10);

        // reset with three queued entries
        for (int i = 0; i < 3; i++) step(1'b1, 5'd30, 1'b1, 5'(21 + i));
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        mq.delete();
        wr_q.delete();
        m_starve = 0;
        m_stall  = 0;
        @(negedge clk);
        reset_n = 1'b1;

        step(1'b0, 5'd0, 1'b1, 5'd3);
        idle(3);

        @(negedge clk);
        @(negedge clk);
        check("wr_q_drained", wr_q.size(), 32'd0);
        check("model_empty",  mq.size(),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
